// File: rtl/rle_stream_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_rle_pkg
// Description : Shared types and default constants for the JPEG run-length
//               stream encoder: FSM state encoding, default coefficient /
//               block / run parameters and derived symbol field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package jpeg_rle_pkg;

    // Width helpers. A run field must hold 0..max_run; the index and
    // zero counters must hold 0..block_len-1.
    function automatic int rle_run_w(input int max_run);
        return (max_run < 1) ? 1 : $clog2(max_run + 1);
    endfunction

    function automatic int rle_idx_w(input int block_len);
        return (block_len < 2) ? 1 : $clog2(block_len);
    endfunction

    localparam int c_DEF_COEF_W    = 11;
    localparam int c_DEF_BLOCK_LEN = 64;
    localparam int c_DEF_MAX_RUN   = 15;
    localparam int c_DEF_RUN_W     = rle_run_w(c_DEF_MAX_RUN);
    localparam int c_DEF_IDX_W     = rle_idx_w(c_DEF_BLOCK_LEN);

    typedef enum logic [1:0] {
        ST_ACCEPT   = 2'd0,
        ST_EMIT_ZRL = 2'd1,
        ST_EMIT_SYM = 2'd2
    } rle_state_t;

endpackage
`default_nettype wire

// File: rtl/rle_stream_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : rle_stream_encoder_if
// Description : Coefficient-in / symbol-out handshake bundle of the
//               run-length encoder.
//   in_valid / in_ready / in_coef : zigzag-ordered coefficient stream
//   out_valid / out_ready         : symbol handshake
//   out_run, out_value            : zero run and nonzero value
//   out_dc, out_zrl, out_eob      : symbol kind flags
//   out_last                      : final symbol of the current block
//   modport master : encoder side;  modport slave : producer/consumer side
// Revision    : 1.0 - initial release
// ============================================================================
interface rle_stream_encoder_if
    import jpeg_rle_pkg::*;
#(
    parameter int COEF_W = c_DEF_COEF_W,
    parameter int RUN_W  = c_DEF_RUN_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [COEF_W-1:0] in_coef;
    logic              out_valid;
    logic              out_ready;
    logic [RUN_W-1:0]  out_run;
    logic [COEF_W-1:0] out_value;
    logic              out_dc;
    logic              out_zrl;
    logic              out_eob;
    logic              out_last;

    modport master (
        input  in_valid, in_coef, out_ready,
        output in_ready, out_valid, out_run, out_value,
               out_dc, out_zrl, out_eob, out_last
    );

    modport slave (
        output in_valid, in_coef, out_ready,
        input  in_ready, out_valid, out_run, out_value,
               out_dc, out_zrl, out_eob, out_last
    );

endinterface
`default_nettype wire

// File: rtl/rle_stream_encoder_sym_reg.sv
`default_nettype none
// ============================================================================
// Module      : rle_sym_reg
// Description : Output symbol register with valid/ready hold. A load always
//               wins (the encoder only loads when the slot is free or being
//               drained this cycle); otherwise valid clears on a handshake
//               and all fields hold while stalled.
//   clk, rst            : clock, asynchronous active-high reset
//   i_load              : capture a new symbol
//   i_ready             : downstream ready
//   i_run .. i_last     : symbol fields to capture
//   o_valid .. o_last   : registered symbol
// Revision    : 1.0 - initial release
// ============================================================================
module rle_sym_reg
    import jpeg_rle_pkg::*;
#(
    parameter int COEF_W = c_DEF_COEF_W,
    parameter int RUN_W  = c_DEF_RUN_W
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_load,
    input  wire logic              i_ready,
    input  wire logic [RUN_W-1:0]  i_run,
    input  wire logic [COEF_W-1:0] i_value,
    input  wire logic              i_dc,
    input  wire logic              i_zrl,
    input  wire logic              i_eob,
    input  wire logic              i_last,
    output logic                   o_valid,
    output logic      [RUN_W-1:0]  o_run,
    output logic      [COEF_W-1:0] o_value,
    output logic                   o_dc,
    output logic                   o_zrl,
    output logic                   o_eob,
    output logic                   o_last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_run   <= '0;
            o_value <= '0;
            o_dc    <= 1'b0;
            o_zrl   <= 1'b0;
            o_eob   <= 1'b0;
            o_last  <= 1'b0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_run   <= i_run;
            o_value <= i_value;
            o_dc    <= i_dc;
            o_zrl   <= i_zrl;
            o_eob   <= i_eob;
            o_last  <= i_last;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rle_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module      : rle_stream_encoder
// Description : JPEG run-length encoder for quantised zigzag coefficients.
//               Emits (run, value) symbols, ZRL for each MAX_RUN+1 zeros that
//               precede a nonzero, and EOB when the block ends on a zero.
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : rle_stream_encoder_if.master (coefficient in, symbol out)
// Revision    : 1.0 - initial release
// ============================================================================
module rle_stream_encoder
    import jpeg_rle_pkg::*;
#(
    parameter int COEF_W    = c_DEF_COEF_W,
    parameter int BLOCK_LEN = c_DEF_BLOCK_LEN,
    parameter int MAX_RUN   = c_DEF_MAX_RUN,
    parameter bit DC_BYPASS = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             reset,
    rle_stream_encoder_if.master  bus
);

    localparam int RUN_W = rle_run_w(MAX_RUN);
    localparam int IDX_W = rle_idx_w(BLOCK_LEN);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(BLOCK_LEN - 1);
    // Only used once zero_cnt exceeds MAX_RUN, which implies it fits IDX_W.
    localparam logic [IDX_W-1:0] c_ZRL_LEN  = IDX_W'(MAX_RUN + 1);
    localparam logic [RUN_W-1:0] c_RUN_MAX  = RUN_W'(MAX_RUN);

    rle_state_t         r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_zero_cnt;
    logic [COEF_W-1:0]  r_val;
    logic               r_last_pend;

    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_blk_end;
    logic               w_is_dc;
    logic               w_coef_nz;
    logic               w_zc_big;
    logic [IDX_W-1:0]   w_zc_after;
    logic               w_after_big;

    logic               w_load;
    logic [RUN_W-1:0]   w_run;
    logic [COEF_W-1:0]  w_value;
    logic               w_dc;
    logic               w_zrl;
    logic               w_eob;
    logic               w_last;

    // Held low during reset so nothing is accepted before the FSM is live.
    assign bus.in_ready = !reset && (r_state == ST_ACCEPT) &&
                          (!bus.out_valid || bus.out_ready);

    assign w_in_fire   = bus.in_valid && bus.in_ready;
    assign w_out_fire  = bus.out_valid && bus.out_ready;
    assign w_blk_end   = (r_idx == c_LAST_IDX);
    assign w_is_dc     = DC_BYPASS && (r_idx == '0);
    assign w_coef_nz   = (bus.in_coef != '0);
    assign w_zc_big    = (int'(r_zero_cnt) > MAX_RUN);
    assign w_zc_after  = r_zero_cnt - c_ZRL_LEN;
    assign w_after_big = (int'(w_zc_after) > MAX_RUN);

    // Next symbol to load into the output register. In the EMIT states the
    // register is always full, so a handshake is exactly the free-slot event.
    always_comb begin
        w_load  = 1'b0;
        w_run   = '0;
        w_value = '0;
        w_dc    = 1'b0;
        w_zrl   = 1'b0;
        w_eob   = 1'b0;
        w_last  = 1'b0;
        case (r_state)
            ST_ACCEPT: begin
                if (w_in_fire) begin
                    if (w_is_dc) begin
                        w_load  = 1'b1;
                        w_value = bus.in_coef;
                        w_dc    = 1'b1;
                    end else if (!w_coef_nz) begin
                        // Trailing zeros collapse into EOB; pending ZRLs drop.
                        if (w_blk_end) begin
                            w_load = 1'b1;
                            w_eob  = 1'b1;
                            w_last = 1'b1;
                        end
                    end else if (w_zc_big) begin
                        w_load = 1'b1;
                        w_zrl  = 1'b1;
                        w_run  = c_RUN_MAX;
                    end else begin
                        w_load  = 1'b1;
                        w_run   = RUN_W'(r_zero_cnt);
                        w_value = bus.in_coef;
                        w_last  = w_blk_end;
                    end
                end
            end
            ST_EMIT_ZRL: begin
                if (w_out_fire) begin
                    w_load = 1'b1;
                    w_zrl  = 1'b1;
                    w_run  = c_RUN_MAX;
                end
            end
            ST_EMIT_SYM: begin
                if (w_out_fire) begin
                    w_load  = 1'b1;
                    w_run   = RUN_W'(r_zero_cnt);
                    w_value = r_val;
                    w_last  = r_last_pend;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_ACCEPT;
            r_idx       <= '0;
            r_zero_cnt  <= '0;
            r_val       <= '0;
            r_last_pend <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCEPT: begin
                    if (w_in_fire) begin
                        r_idx <= w_blk_end ? '0 : r_idx + 1'b1;
                        if (w_is_dc) begin
                            r_zero_cnt <= '0;
                        end else if (!w_coef_nz) begin
                            r_zero_cnt <= w_blk_end ? '0 : r_zero_cnt + 1'b1;
                        end else if (w_zc_big) begin
                            // First ZRL goes out now; the value waits in r_val.
                            r_zero_cnt  <= w_zc_after;
                            r_val       <= bus.in_coef;
                            r_last_pend <= w_blk_end;
                            r_state     <= w_after_big ? ST_EMIT_ZRL : ST_EMIT_SYM;
                        end else begin
                            r_zero_cnt <= '0;
                        end
                    end
                end
                ST_EMIT_ZRL: begin
                    if (w_out_fire) begin
                        r_zero_cnt <= w_zc_after;
                        if (!w_after_big) begin
                            r_state <= ST_EMIT_SYM;
                        end
                    end
                end
                ST_EMIT_SYM: begin
                    if (w_out_fire) begin
                        r_zero_cnt <= '0;
                        r_state    <= ST_ACCEPT;
                    end
                end
                default: r_state <= ST_ACCEPT;
            endcase
        end
    end

    rle_sym_reg #(
        .COEF_W (COEF_W),
        .RUN_W  (RUN_W)
    ) u_sym_reg (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_load),
        .i_ready (bus.out_ready),
        .i_run   (w_run),
        .i_value (w_value),
        .i_dc    (w_dc),
        .i_zrl   (w_zrl),
        .i_eob   (w_eob),
        .i_last  (w_last),
        .o_valid (bus.out_valid),
        .o_run   (bus.out_run),
        .o_value (bus.out_value),
        .o_dc    (bus.out_dc),
        .o_zrl   (bus.out_zrl),
        .o_eob   (bus.out_eob),
        .o_last  (bus.out_last)
    );

endmodule
`default_nettype wire

// File: tb/tb_rle_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rle_stream_encoder
// Description : Self-checking bench. Instance A uses the default parameters,
//               instance B uses BLOCK_LEN=16, MAX_RUN=3, DC_BYPASS=0.
//               Directed vectors carry hand-derived symbol lists; random
//               blocks are checked against a reference encoder and by
//               decoding the emitted symbols back into a block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rle_stream_encoder;

    typedef struct packed {
        logic [3:0]         run;
        logic signed [10:0] value;
        logic               dc;
        logic               zrl;
        logic               eob;
        logic               last;
    } sym_t;

    typedef struct {
        int         which;
        int         p0;
        int         v0;
        int         p1;
        int         v1;
        int         n_exp;
        int         exp_lo;
        sym_t [5:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   rdy_mode = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   blk [64];
    sym_t q_a [$];
    sym_t q_b [$];
    sym_t exp_q [$];
    int   lo_a = 0;
    int   lo_b = 0;
    bit   stall_a = 1'b0;
    bit   stall_b = 1'b0;
    sym_t held_a;
    sym_t held_b;
    vec_t tv [8];

    rle_stream_encoder_if #(.COEF_W(11), .RUN_W(4)) bus_a ();
    rle_stream_encoder_if #(.COEF_W(11), .RUN_W(2)) bus_b ();

    rle_stream_encoder #(.COEF_W(11), .BLOCK_LEN(64), .MAX_RUN(15), .DC_BYPASS(1'b1))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    rle_stream_encoder #(.COEF_W(11), .BLOCK_LEN(16), .MAX_RUN(3), .DC_BYPASS(1'b0))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic sym_t mk(input int run, input int val, input bit dc, input bit zrl,
                                input bit eob, input bit last);
        sym_t s;
        s.run = 4'(run); s.value = 11'(val);
        s.dc = dc; s.zrl = zrl; s.eob = eob; s.last = last;
        return s;
    endfunction

    function automatic sym_t cur_a();
        return mk(int'(bus_a.out_run), int'($signed(bus_a.out_value)), bus_a.out_dc,
                  bus_a.out_zrl, bus_a.out_eob, bus_a.out_last);
    endfunction

    function automatic sym_t cur_b();
        return mk(int'(bus_b.out_run), int'($signed(bus_b.out_value)), bus_b.out_dc,
                  bus_b.out_zrl, bus_b.out_eob, bus_b.out_last);
    endfunction

    function automatic int blen(input int which);
        return (which == 0) ? 64 : 16;
    endfunction

    function automatic int mrun(input int which);
        return (which == 0) ? 15 : 3;
    endfunction

    // Symbol collector and stall-stability checker.
    always @(negedge clk) begin
        if (reset) begin
            stall_a = 1'b0;
            stall_b = 1'b0;
        end else begin
            if (stall_a) chk("hold_a", 32'({bus_a.out_valid, cur_a()}), 32'({1'b1, held_a}));
            if (stall_b) chk("hold_b", 32'({bus_b.out_valid, cur_b()}), 32'({1'b1, held_b}));
            if (bus_a.out_valid && bus_a.out_ready) q_a.push_back(cur_a());
            if (bus_b.out_valid && bus_b.out_ready) q_b.push_back(cur_b());
            stall_a = bus_a.out_valid && !bus_a.out_ready;
            stall_b = bus_b.out_valid && !bus_b.out_ready;
            held_a  = cur_a();
            held_b  = cur_b();
            if (!bus_a.in_ready) lo_a++;
            if (!bus_b.in_ready) lo_b++;
        end
    end

    always @(posedge clk) begin
        #1;
        bus_a.out_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        bus_b.out_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic set_in(input int which, input logic v, input int c);
        if (which == 0) begin bus_a.in_valid = v; bus_a.in_coef = 11'(c); end
        else            begin bus_b.in_valid = v; bus_b.in_coef = 11'(c); end
    endtask

    task automatic feed(input int which, input int len);
        int i = 0;
        int guard = 0;
        while (i < len && guard < 4000) begin
            @(posedge clk); #1;
            set_in(which, 1'b1, blk[i]);
            @(negedge clk);
            guard++;
            if ((which == 0) ? bus_a.in_ready : bus_b.in_ready) i++;
        end
        @(posedge clk); #1;
        set_in(which, 1'b0, 0);
        if (i < len) begin
            n_chk++; n_fail++;
            $display("FAIL feed_timeout: accepted %0d, required %0d", i, len);
        end
    endtask

    task automatic drain(input int which);
        int g = 0;
        int quiet = 0;
        while (quiet < 3 && g < 1000) begin
            @(negedge clk);
            g++;
            if ((which == 0) ? bus_a.out_valid : bus_b.out_valid) quiet = 0;
            else quiet++;
        end
        if (quiet < 3) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: out_valid still high after %0d cycles, required low", g);
        end
    endtask

    task automatic run_block(input int which);
        q_a.delete(); q_b.delete();
        lo_a = 0; lo_b = 0;
        feed(which, blen(which));
        drain(which);
    endtask

    // Reference encoder: walk the block, counting zeros; a nonzero first
    // pays out whole ZRL groups, a zero in the final slot becomes EOB.
    task automatic ref_encode(input int which);
        int run = 0;
        int n = blen(which);
        int mr = mrun(which);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            if (which == 0 && i == 0) begin
                exp_q.push_back(mk(0, blk[i], 1'b1, 1'b0, 1'b0, 1'b0));
            end else if (blk[i] == 0) begin
                if (i == n - 1) exp_q.push_back(mk(0, 0, 1'b0, 1'b0, 1'b1, 1'b1));
                else run++;
            end else begin
                while (run > mr) begin
                    exp_q.push_back(mk(mr, 0, 1'b0, 1'b1, 1'b0, 1'b0));
                    run -= mr + 1;
                end
                exp_q.push_back(mk(run, blk[i], 1'b0, 1'b0, 1'b0, (i == n - 1)));
                run = 0;
            end
        end
    endtask

    task automatic compare_q(input int which, input string tag);
        sym_t got [$];
        if (which == 0) got = q_a; else got = q_b;
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got.size(); k++)
            chk($sformatf("%s_sym%0d", tag, k), 32'(got[k]), 32'(exp_q[k]));
    endtask

    task automatic decode_check(input int which, input string tag);
        sym_t got [$];
        int rec [64];
        int pos = 0;
        int bad = 0;
        int n = blen(which);
        if (which == 0) got = q_a; else got = q_b;
        for (int i = 0; i < 64; i++) rec[i] = 0;
        foreach (got[k]) begin
            if (got[k].eob) pos = n;
            else if (got[k].zrl) pos += mrun(which) + 1;
            else begin
                pos += int'(got[k].run);
                if (pos < n) rec[pos] = int'($signed(got[k].value));
                pos++;
            end
        end
        for (int i = 0; i < n; i++) if (rec[i] != blk[i]) bad++;
        chk({tag, "_decode"}, 32'(bad), 32'd0);
    endtask

    task automatic gen_block(input int which);
        int pct;
        int v;
        case ($urandom_range(0, 2))
            0: pct = 4;
            1: pct = 20;
            default: pct = 60;
        endcase
        for (int i = 0; i < 64; i++) begin
            blk[i] = 0;
            if (i < blen(which) && int'($urandom_range(0, 99)) < pct) begin
                v = int'($urandom_range(1, 1023));
                blk[i] = ($urandom_range(0, 1) != 0) ? -v : v;
            end
        end
    endtask

    task automatic setv(input int c, input int which, input int p0, input int v0,
                        input int p1, input int v1, input int n, input int lo);
        tv[c].which = which; tv[c].p0 = p0; tv[c].v0 = v0;
        tv[c].p1 = p1; tv[c].v1 = v1; tv[c].n_exp = n; tv[c].exp_lo = lo;
        tv[c].exp = '0;
    endtask

    initial begin
        sym_t zrl_a, zrl_b, eob;
        zrl_a = mk(15, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        zrl_b = mk(3, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        eob   = mk(0, 0, 1'b0, 1'b0, 1'b1, 1'b1);

        setv(0, 0, 0, 5, 3, 3, 3, 0);
        tv[0].exp[0] = mk(0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        tv[0].exp[1] = mk(2, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        tv[0].exp[2] = eob;
        setv(1, 0, 0, -7, 63, 9, 5, 3);
        tv[1].exp[0] = mk(0, -7, 1'b1, 1'b0, 1'b0, 1'b0);
        tv[1].exp[1] = zrl_a; tv[1].exp[2] = zrl_a; tv[1].exp[3] = zrl_a;
        tv[1].exp[4] = mk(14, 9, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 2; c < 4; c++) begin
            setv(c, 0, -1, 0, -1, 0, 2, 0);
            tv[c].exp[0] = mk(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
            tv[c].exp[1] = eob;
        end
        setv(4, 1, 9, 4, -1, 0, 4, 2);
        tv[4].exp[0] = zrl_b; tv[4].exp[1] = zrl_b;
        tv[4].exp[2] = mk(1, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        tv[4].exp[3] = eob;
        setv(5, 0, 1, -1, 17, 2, 4, 0);
        tv[5].exp[0] = mk(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        tv[5].exp[1] = mk(0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        tv[5].exp[2] = mk(15, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        tv[5].exp[3] = eob;
        setv(6, 0, 1, 1, 18, -3, 5, 1);
        tv[6].exp[0] = mk(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        tv[6].exp[1] = mk(0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        tv[6].exp[2] = zrl_a;
        tv[6].exp[3] = mk(0, -3, 1'b0, 1'b0, 1'b0, 1'b0);
        tv[6].exp[4] = eob;
        setv(7, 1, 0, -2, 15, 7, 5, 3);
        tv[7].exp[0] = mk(0, -2, 1'b0, 1'b0, 1'b0, 1'b0);
        tv[7].exp[1] = zrl_b; tv[7].exp[2] = zrl_b; tv[7].exp[3] = zrl_b;
        tv[7].exp[4] = mk(2, 7, 1'b0, 1'b0, 1'b0, 1'b1);

        reset = 1'b1;
        set_in(0, 1'b0, 0);
        set_in(1, 1'b0, 0);
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_a_out", 32'({bus_a.out_valid, cur_a()}), 32'd0);
        chk("rst_a_in_ready", 32'(bus_a.in_ready), 32'd0);
        chk("rst_b_out", 32'({bus_b.out_valid, cur_b()}), 32'd0);
        chk("rst_b_in_ready", 32'(bus_b.in_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_a_in_ready", 32'(bus_a.in_ready), 32'd1);

        // Directed vectors, out_ready held high.
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 64; i++) blk[i] = 0;
            if (tv[c].p0 >= 0) blk[tv[c].p0] = tv[c].v0;
            if (tv[c].p1 >= 0) blk[tv[c].p1] = tv[c].v1;
            run_block(tv[c].which);
            exp_q.delete();
            for (int k = 0; k < tv[c].n_exp; k++) exp_q.push_back(tv[c].exp[k]);
            compare_q(tv[c].which, $sformatf("vec%0d", c));
            chk($sformatf("vec%0d_in_ready_low", c),
                32'((tv[c].which == 0) ? lo_a : lo_b), 32'(tv[c].exp_lo));
        end

        // Random blocks with 50% out_ready back-pressure.
        rdy_mode = 1;
        for (int b = 0; b < 10; b++) begin
            int which;
            which = (b % 3 == 2) ? 1 : 0;
            gen_block(which);
            ref_encode(which);
            run_block(which);
            compare_q(which, $sformatf("rnd%0d", b));
            decode_check(which, $sformatf("rnd%0d", b));
        end
        rdy_mode = 0;
        repeat (2) @(posedge clk);

        // Reset mid-block at index 20 while a symbol is pending.
        for (int i = 0; i < 64; i++) blk[i] = i + 1;
        feed(0, 21);
        chk("rst_mid_pre_valid", 32'(bus_a.out_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_async_out", 32'({bus_a.out_valid, cur_a()}), 32'd0);
        chk("rst_mid_in_ready", 32'(bus_a.in_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 64; i++) blk[i] = 0;
        blk[0] = 5; blk[3] = 3;
        ref_encode(0);
        run_block(0);
        compare_q(0, "post_rst");
        decode_check(0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rle_stream_encoder.md
Name: rle_stream_encoder

Overview:
- Parametrised run-length encoder for quantised, zigzag-ordered DCT coefficients in the JPEG entropy path.
- Accepts one coefficient per cycle over a valid/ready handshake.
- Emits JPEG-style (run, value) symbols, including ZRL (16-zero) and EOB markers, with full back-pressure.
- Sits between the quantiser/zigzag stage and the Huffman size/code stage; replaces the fixed 8-lane, cnt-driven encoder.

Parameters:
- COEF_W, 11, signed coefficient width.
- BLOCK_LEN, 64, coefficients per block; at least 2.
- MAX_RUN, 15, largest run in one symbol; a ZRL stands for MAX_RUN+1 zeros.
- DC_BYPASS, 1, 1 = index 0 is always emitted as a run-0 DC symbol, even when zero.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  coefficient valid.
- in_ready  out  1  encoder can accept a coefficient this cycle.
- in_coef  in  COEF_W  coefficient, zigzag order.
- out_valid  out  1  symbol valid.
- out_ready  in  1  downstream accepts the symbol.
- out_run  out  clog2(MAX_RUN+1)  zero run preceding out_value.
- out_value  out  COEF_W  nonzero coefficient; 0 for ZRL/EOB.
- out_dc  out  1  symbol is the DC term.
- out_zrl  out  1  symbol is ZRL (run=MAX_RUN, value=0).
- out_eob  out  1  symbol is EOB (run=0, value=0).
- out_last  out  1  final symbol of the current block.

Behaviour:
- Reset (async, active-high): out_valid=0, all out_* fields=0, in_ready=0 while reset is asserted.
  - Internal: idx=0, zero_cnt=0, state=ACCEPT.
  - Reset mid-block discards the partial block; the next accepted coefficient is index 0.
- Handshake:
  - Input transfer happens when in_valid && in_ready.
  - Output transfer happens when out_valid && out_ready.
  - out_* fields are held stable while out_valid && !out_ready.
  - in_ready = (state==ACCEPT) && (!out_valid || out_ready). No combinational path from in_valid to out_*.
- Latency: a coefficient that produces a symbol directly shows out_valid in the cycle after acceptance. Throughput is 1 symbol/cycle when out_ready is held high.
- State machine states: ACCEPT, EMIT_ZRL, EMIT_SYM.
  - ACCEPT, idx==0 and DC_BYPASS: emit {run=0, value=in_coef, out_dc=1}. zero_cnt stays 0.
  - ACCEPT, zero coefficient, idx<BLOCK_LEN-1: zero_cnt += 1, no symbol.
  - ACCEPT, nonzero coefficient, zero_cnt<=MAX_RUN: emit {run=zero_cnt, value}, then zero_cnt=0.
  - ACCEPT, nonzero coefficient, zero_cnt>MAX_RUN:
    - Latch the value and emit a ZRL; zero_cnt -= MAX_RUN+1.
    - Next state is EMIT_ZRL if zero_cnt is still >MAX_RUN, else EMIT_SYM.
  - EMIT_ZRL: on each output handshake, emit another ZRL and subtract MAX_RUN+1; move to EMIT_SYM when zero_cnt<=MAX_RUN.
  - EMIT_SYM: on output handshake, emit the latched {run=zero_cnt, value}, clear zero_cnt, return to ACCEPT.
- Block end (idx==BLOCK_LEN-1):
  - Coefficient zero: emit EOB with out_last=1. Pending zeros and ZRLs are discarded, never emitted.
  - Coefficient nonzero: emit any required ZRLs, then the symbol with out_last=1. No EOB is emitted.
  - idx wraps to 0 on the accept of index BLOCK_LEN-1.
- DC_BYPASS=0: index 0 is treated like any AC coefficient.
- Widths:
  - zero_cnt and idx are clog2(BLOCK_LEN) bits.
  - zero_cnt cannot overflow, because it is bounded by BLOCK_LEN-1.
  - out_value passes in_coef bit-exact; there is no sign manipulation.
- Simultaneous events: an output handshake and an input accept in the same cycle are legal. The output register reloads with the new symbol with no bubble.

Decomposition:
- Package jpeg_rle_pkg holds:
  - state encodings ST_ACCEPT, ST_EMIT_ZRL, ST_EMIT_SYM;
  - default constants COEF_W=11, BLOCK_LEN=64, MAX_RUN=15;
  - symbol field widths.
- One sub-module is natural: rle_sym_reg. It is the output symbol register with valid/ready hold logic, parametrised by COEF_W and run width. The FSM and counters stay in the top module.

Test Plan:
- Block [5, 0, 0, 3, then 60 zeros], out_ready=1 → symbols (0,5,dc), (2,3), EOB with out_last=1; 3 symbols total.
- Block of 62 zeros after DC=-7, index 63 = 9 → (0,-7,dc), ZRL, ZRL, ZRL, (14,9,last); no EOB; in_ready low for 3 cycles during the ZRL burst.
- All-zero block → (0,0,dc), then EOB with out_last; exactly 2 symbols; a second back-to-back block gives the same result (idx wraps).
- Random coefficients with out_ready toggled 50% → no symbol dropped or duplicated; fields stable while stalled; decoded reconstruction equals the input block.
- Reset asserted at index 20 mid-block with out_valid=1 → out_valid=0 immediately (async); the next block encodes correctly from index 0.
- BLOCK_LEN=16, MAX_RUN=3, DC_BYPASS=0, block [0×9, 4, 0×6] → ZRL, ZRL, (1,4), EOB with out_last.
